// File: rtl/load_seq_ctrl_pkg.sv
// Shared types and constants for the load sequencing controller.
package load_seq_ctrl_pkg;

  localparam int unsigned DEFAULT_TIMEOUT = 255;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned TYPE_W          = 3;
  localparam int unsigned DST_W           = 5;

  typedef enum logic [TYPE_W-1:0] {
    LT_LW  = 3'd0,
    LT_LH  = 3'd1,
    LT_LHU = 3'd2,
    LT_LB  = 3'd3,
    LT_LBU = 3'd4,
    LT_LWR = 3'd5
  } ld_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_FMT  = 2'd2,
    S_EXC  = 2'd3
  } state_e;

  // Request fields captured at acceptance
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TYPE_W-1:0] ld_type;
    logic [DATA_W-1:0] v2;
    logic [DST_W-1:0]  dst;
  } ld_req_t;

  // Unknown type codes fall through to word alignment rules
  function automatic logic is_misaligned(logic [TYPE_W-1:0] t, logic [1:0] b);
    logic mis;
    case (t)
      LT_LH, LT_LHU:         mis = b[0];
      LT_LB, LT_LBU, LT_LWR: mis = 1'b0;
      default:               mis = (b != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_seq_ctrl_if.sv
// Load request, bus read and writeback/exception signals of the load controller.
interface load_seq_ctrl_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_type;
  logic [31:0] ld_v2;
  logic [4:0]  ld_dst;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;
  logic        exc_adel;
  logic        exc_bus;
  logic [31:0] exc_badvaddr;
  logic        busy;

  // Controller side
  modport slave (
    input  ld_valid, ld_addr, ld_type, ld_v2, ld_dst, bus_ack, bus_err, bus_rdata,
    output ld_ready, bus_req, bus_addr, wb_valid, wb_data, wb_dst,
           exc_adel, exc_bus, exc_badvaddr, busy
  );

  // Pipeline/bus environment side
  modport master (
    output ld_valid, ld_addr, ld_type, ld_v2, ld_dst, bus_ack, bus_err, bus_rdata,
    input  ld_ready, bus_req, bus_addr, wb_valid, wb_data, wb_dst,
           exc_adel, exc_bus, exc_badvaddr, busy
  );
endinterface

// File: rtl/load_seq_ctrl_formatter.sv
// Extracts, extends or merges the loaded word according to load type and byte offset.
module load_formatter
  import load_seq_ctrl_pkg::*;
(
  input  logic [TYPE_W-1:0] ld_type,
  input  logic [1:0]        b,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] v2,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword loads are always even-aligned here, so only b[1] picks the half
  assign byte_sel = rdata[{b, 3'b000} +: 8];
  assign half_sel = rdata[{b[1], 4'b0000} +: 16];

  always_comb begin
    data = rdata;
    case (ld_type)
      LT_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU: data = {24'd0, byte_sel};
      LT_LH:  data = {{16{half_sel[15]}}, half_sel};
      LT_LHU: data = {16'd0, half_sel};
      LT_LWR: begin
        case (b)
          2'd0:    data = rdata;
          2'd1:    data = {v2[31:24], rdata[31:8]};
          2'd2:    data = {v2[31:16], rdata[31:16]};
          default: data = {v2[31:8],  rdata[31:24]};
        endcase
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_seq_ctrl.sv
// Sequences a single load: accept, bus read with timeout, format, then writeback or exception.
module load_seq_ctrl
  import load_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset_n,
  load_seq_ctrl_if.slave ls
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  ld_req_t             req_q, req_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [DST_W-1:0]    wb_dst_q, wb_dst_d;
  logic [ADDR_W-1:0]   badvaddr_q, badvaddr_d;
  logic                wb_valid_q, wb_valid_d;
  logic                exc_adel_q, exc_adel_d;
  logic                exc_bus_q, exc_bus_d;
  logic                ld_ready_q, busy_q, bus_req_q;
  logic [DATA_W-1:0]   fmt_data;

  load_formatter u_fmt (
    .ld_type (req_q.ld_type),
    .b       (req_q.addr[1:0]),
    .rdata   (rdata_q),
    .v2      (req_q.v2),
    .data    (fmt_data)
  );

  // Exception pulses are raised on entry to EXC so they coincide with that state
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    bus_addr_d = bus_addr_q;
    wb_data_d  = wb_data_q;
    wb_dst_d   = wb_dst_q;
    badvaddr_d = badvaddr_q;
    wb_valid_d = 1'b0;
    exc_adel_d = 1'b0;
    exc_bus_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ls.ld_valid) begin
          req_d = '{addr: ls.ld_addr, ld_type: ls.ld_type, v2: ls.ld_v2, dst: ls.ld_dst};
          cnt_d = '0;
          if (is_misaligned(ls.ld_type, ls.ld_addr[1:0])) begin
            state_d    = S_EXC;
            exc_adel_d = 1'b1;
            badvaddr_d = ls.ld_addr;
          end else begin
            state_d    = S_BUS;
            bus_addr_d = {ls.ld_addr[31:2], 2'b00};
          end
        end
      end
      S_BUS: begin
        if (ls.bus_ack) begin
          if (ls.bus_err) begin
            state_d    = S_EXC;
            exc_bus_d  = 1'b1;
            badvaddr_d = req_q.addr;
          end else begin
            state_d = S_FMT;
            rdata_d = ls.bus_rdata;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = S_EXC;
          exc_bus_d  = 1'b1;
          badvaddr_d = req_q.addr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FMT: begin
        state_d    = S_IDLE;
        wb_valid_d = 1'b1;
        wb_data_d  = fmt_data;
        wb_dst_d   = req_q.dst;
      end
      S_EXC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track the FSM exactly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      bus_addr_q <= '0;
      wb_data_q  <= '0;
      wb_dst_q   <= '0;
      badvaddr_q <= '0;
      wb_valid_q <= 1'b0;
      exc_adel_q <= 1'b0;
      exc_bus_q  <= 1'b0;
      ld_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      bus_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      bus_addr_q <= bus_addr_d;
      wb_data_q  <= wb_data_d;
      wb_dst_q   <= wb_dst_d;
      badvaddr_q <= badvaddr_d;
      wb_valid_q <= wb_valid_d;
      exc_adel_q <= exc_adel_d;
      exc_bus_q  <= exc_bus_d;
      ld_ready_q <= (state_d == S_IDLE);
      busy_q     <= (state_d != S_IDLE);
      bus_req_q  <= (state_d == S_BUS);
    end
  end

  assign ls.ld_ready     = ld_ready_q;
  assign ls.busy         = busy_q;
  assign ls.bus_req      = bus_req_q;
  assign ls.bus_addr     = bus_addr_q;
  assign ls.wb_valid     = wb_valid_q;
  assign ls.wb_data      = wb_data_q;
  assign ls.wb_dst       = wb_dst_q;
  assign ls.exc_adel     = exc_adel_q;
  assign ls.exc_bus      = exc_bus_q;
  assign ls.exc_badvaddr = badvaddr_q;

endmodule

// File: doc/load_seq_ctrl.md
LOAD_SEQ_CTRL -- requirements
Module: load_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of bus wait cycles before a load aborts with a bus error.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port ld_valid  in  1  load request from the MEM stage.
REQ-005 SHALL have port ld_ready  out  1  request accepted in any cycle where ld_valid and ld_ready are both high.
REQ-006 SHALL have port ld_addr  in  32  byte address.
REQ-007 SHALL have port ld_type  in  3  load type: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 LWR; codes 6 and 7 behave as LW.
REQ-008 SHALL have port ld_v2  in  32  old rt value, used by LWR merge.
REQ-009 SHALL have port ld_dst  in  5  destination register.
REQ-010 SHALL have port bus_req  out  1  read request, held until acknowledged.
REQ-011 SHALL have port bus_addr  out  32  word-aligned read address, {addr[31:2],2'b00}.
REQ-012 SHALL have ports bus_ack  in  1, bus_err  in  1 (valid only with bus_ack), and bus_rdata  in  32, sampled on bus_ack.
REQ-013 SHALL have ports wb_valid  out  1  one-cycle result pulse; wb_data  out  32; wb_dst  out  5.
REQ-014 SHALL have ports exc_adel  out  1  one-cycle misalignment pulse; exc_bus  out  1  one-cycle bus-fault pulse; exc_badvaddr  out  32  faulting byte address.
REQ-015 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, BUS, FMT, EXC; ld_ready is high only in IDLE.
REQ-017 Acceptance in IDLE SHALL latch addr, type, v2 and dst, then go to EXC if misaligned, otherwise to BUS.
REQ-018 Misalignment SHALL be defined as LW with addr[1:0]!=0, or LH/LHU with addr[0]!=0; LB, LBU and LWR are never misaligned.
REQ-019 In BUS, bus_req SHALL be 1 and bus_addr stable; the timeout counter increments each cycle without bus_ack.
REQ-020 In BUS, bus_ack with bus_err=0 SHALL capture bus_rdata and go to FMT; bus_ack with bus_err=1 SHALL go to EXC (bus fault).
REQ-021 In BUS, if the counter reaches TIMEOUT_CYCLES with no ack, the FSM SHALL go to EXC (bus fault); bus_req SHALL drop in the same transition cycle.
REQ-022 FMT SHALL last 1 cycle, asserting wb_valid with wb_data and wb_dst, then return to IDLE; best-case latency is accept -> wb_valid in 3 cycles with a 0-wait ack.
REQ-023 EXC SHALL last 1 cycle, asserting exactly one of exc_adel or exc_bus with exc_badvaddr equal to the latched address, then return to IDLE; wb_valid SHALL stay 0.
REQ-024 Formatting with b=addr[1:0] and R the captured word SHALL be: LB/LBU sign- or zero-extend R[8b+7:8b]; LH/LHU sign- or zero-extend R[8b+15:8b]; LW gives R.
REQ-025 LWR SHALL give: b=0 -> R; b=1 -> {v2[31:24],R[31:8]}; b=2 -> {v2[31:16],R[31:16]}; b=3 -> {v2[31:8],R[31:24]}.
REQ-026 A bus_ack arriving outside BUS SHALL be ignored; ld_valid outside IDLE SHALL not be accepted.
REQ-027 wb_data, wb_dst and exc_badvaddr SHALL be registered outputs and hold their values when their pulse is low.

Reset
REQ-028 While reset_n=0, the block SHALL be in IDLE with ld_ready=1 and all other outputs 0, the counter 0 and the latches 0.
REQ-029 Reset asserted mid-BUS SHALL drop bus_req immediately and discard the pending load with no wb or exc pulse.

Structure
REQ-030 The package SHALL hold the ld_type codes, the FSM state enum and the default timeout constant.
REQ-031 The purely combinational formatter SHALL be a separate sub-module, load_formatter (inputs type, b, R, v2; output data).

Verification
REQ-032 LBU at 0x1003, rdata 0x80FF_1234, ack after 2 waits -> wb_valid with wb_data 0x0000_0080, 5 cycles after accept.
REQ-033 LH at 0x2002, rdata 0x8001_0000, 0-wait ack -> wb_data 0xFFFF_8001, 3 cycles after accept.
REQ-034 LWR at 0x3001, v2 0xAABB_CCDD, rdata 0x1122_3344 -> wb_data 0xAA11_2233.
REQ-035 LW at 0x4002 -> exc_adel pulse, exc_badvaddr 0x4002, bus_req never asserted, ld_ready back to 1 next cycle.
REQ-036 LW at 0x5000, no ack, TIMEOUT_CYCLES=4 -> exc_bus pulse after 4 wait cycles; a separate case with ack+bus_err -> exc_bus; reset_n low mid-BUS -> bus_req 0 asynchronously and no pulses.
